decoder_pulse_t: RTL and testbench



---
 rtl/decoder_pulse_t_if.sv | 24 ++
 rtl/decoder_pulse_t.sv | 114 +++++++++++
 tb/tb_decoder_pulse_t.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/decoder_pulse_t_if.sv
// Bundle between a pulse-code receiver and its surroundings: window control
// and pulse line in, decoded thermometer result and status out.
`timescale 1ns/1ps
interface decoder_pulse_t_if;
  logic       window_start;
  logic       incoming_line;
  logic [7:0] outgoing_line;
  logic       outgoing_line_valid;
  logic [3:0] pulse_time;
  logic       timeout;
  logic       busy;

  // Side that opens windows and drives the pulse line.
  modport master (
    output window_start, incoming_line,
    input  outgoing_line, outgoing_line_valid, pulse_time, timeout, busy
  );

  // Decoder side.
  modport slave (
    input  window_start, incoming_line,
    output outgoing_line, outgoing_line_valid, pulse_time, timeout, busy
  );
endinterface

// File: rtl/decoder_pulse_t.sv
// Temporal pulse-code receiver. Measures how many cycles after a window opens
// the active-low pulse arrives and turns that offset k into 8'hFF >> k.
// A window with no pulse in offsets 0..MAX_VALUE-1 reports a timeout.
// Optional build macro DECODER_PULSE_EDGE_EN: detect a high-to-low transition
// instead of a low level, so a line stuck low never decodes.
`timescale 1ns/1ps
module decoder_pulse_t #(
  parameter int MAX_VALUE = 8  // window length in cycles, 1..8
) (
  input logic              clock,
  input logic              reset,
  decoder_pulse_t_if.slave bus
);

  localparam logic [3:0] LAST_OFFSET = 4'(MAX_VALUE - 1);
  localparam logic [3:0] TIMEOUT_K   = 4'(MAX_VALUE);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t     state_q, state_d;
  logic [7:0] code_q;
  logic [3:0] elapsed_q;
  logic       pulse_seen;
  logic       done_pulse;
  logic       done_timeout;

`ifdef DECODER_PULSE_EDGE_EN
  logic line_prev_q;

  // Previous line sample; the window_start cycle's sample serves cycle 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) line_prev_q <= 1'b1;
    else       line_prev_q <= bus.incoming_line;
  end

  assign pulse_seen = ~bus.incoming_line & line_prev_q;
`else
  assign pulse_seen = ~bus.incoming_line;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: every clocked assignment is non-blocking so all registers update
    // from the same pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and end-of-window decisions.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal; no latches.
    state_d      = state_q;
    done_pulse   = 1'b0;
    done_timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.window_start) state_d = COUNT;
      end
      COUNT: begin
        if (pulse_seen) begin
          done_pulse = 1'b1;
          state_d    = IDLE;
        end else if (elapsed_q == LAST_OFFSET) begin
          done_timeout = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window datapath: shifting code and elapsed-cycle counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      code_q    <= 8'hFF;
      elapsed_q <= 4'd0;
    end else if (state_q == IDLE) begin
      if (bus.window_start) begin
        code_q    <= 8'hFF;
        elapsed_q <= 4'd0;
      end
    end else if (!done_pulse && !done_timeout) begin
      // A shift only empties the code, so it can never wrap below 8'h00.
      code_q    <= code_q >> 1;
      elapsed_q <= elapsed_q + 4'd1;
    end
  end

  // Registered result; valid and timeout are single-cycle strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.outgoing_line       <= 8'h00;
      bus.pulse_time          <= 4'd0;
      bus.outgoing_line_valid <= 1'b0;
      bus.timeout             <= 1'b0;
    end else begin
      bus.outgoing_line_valid <= done_pulse | done_timeout;
      bus.timeout             <= done_timeout;
      if (done_pulse) begin
        bus.outgoing_line <= code_q;
        bus.pulse_time    <= elapsed_q;
      end else if (done_timeout) begin
        bus.outgoing_line <= 8'h00;
        bus.pulse_time    <= TIMEOUT_K;
      end
    end
  end

  // Status output.
  always_comb begin
    bus.busy = (state_q == COUNT);
  end

endmodule

// File: tb/tb_decoder_pulse_t.sv
// Directed bench for decoder_pulse_t. Stimulus pushes the hand-computed result
// and the cycle it must appear in; a monitor pops and compares on each valid.
// A second instance with MAX_VALUE=4 covers the short-window timeout.
`timescale 1ns/1ps
module tb_decoder_pulse_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  decoder_pulse_t_if bus8();
  decoder_pulse_t_if bus4();

  decoder_pulse_t #(.MAX_VALUE(8)) dut8 (.clock(clock), .reset(reset), .bus(bus8.slave));
  decoder_pulse_t #(.MAX_VALUE(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4.slave));

  typedef struct {
    logic [7:0] line;
    logic [3:0] pt;
    logic       to;
    int         at;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    exp_t e;
    if (bus8.outgoing_line_valid === 1'b1) begin
      if (q8.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_valid8: got valid, expected none (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        check("line8",    32'(bus8.outgoing_line), 32'(e.line));
        check("ptime8",   32'(bus8.pulse_time),    32'(e.pt));
        check("timeout8", 32'(bus8.timeout),       32'(e.to));
        check("cycle8",   32'(cyc),                32'(e.at));
      end
    end
    if (bus4.outgoing_line_valid === 1'b1) begin
      if (q4.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_valid4: got valid, expected none (cycle %0d)", cyc);
      end else begin
        e = q4.pop_front();
        check("line4",    32'(bus4.outgoing_line), 32'(e.line));
        check("ptime4",   32'(bus4.pulse_time),    32'(e.pt));
        check("timeout4", 32'(bus4.timeout),       32'(e.to));
        check("cycle4",   32'(cyc),                32'(e.at));
      end
    end
  end

  // One cycle of input drive, applied at the falling edge.
  task automatic step(input bit sel4, input logic ws, input logic ln);
    @(negedge clock);
    if (sel4) begin
      bus4.window_start  = ws;
      bus4.incoming_line = ln;
    end else begin
      bus8.window_start  = ws;
      bus8.incoming_line = ln;
    end
  endtask

  task automatic push(input bit sel4, input logic [7:0] l, input logic [3:0] p,
                      input logic t, input int at);
    exp_t e;
    e.line = l; e.pt = p; e.to = t; e.at = at;
    if (sel4) q4.push_back(e);
    else      q8.push_back(e);
  endtask

  // Open a window, pull the line low for one cycle at offset k (none if k<0),
  // expect the given result lat cycles after the window_start cycle.
  task automatic win(input bit sel4, input int k, input int len, input logic [7:0] el,
                     input logic [3:0] ep, input logic eto, input int lat);
    int s;
    step(sel4, 1'b1, 1'b1);
    s = cyc;
    push(sel4, el, ep, eto, s + lat);
    for (int i = 0; i < len; i++) begin
      step(sel4, 1'b0, (i == k) ? 1'b0 : 1'b1);
      if (i == 0) check("busy_in_window", 32'(sel4 ? bus4.busy : bus8.busy), 32'd1);
    end
    step(sel4, 1'b0, 1'b1);
    step(sel4, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int s;
    int k;
    logic [7:0] vals [4];
    vals = '{8'hFF, 8'h3F, 8'h07, 8'h01};

    reset = 1'b1;
    bus8.window_start = 1'b0; bus8.incoming_line = 1'b1;
    bus4.window_start = 1'b0; bus4.incoming_line = 1'b1;
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    check("rst_line",    32'(bus8.outgoing_line),       32'h00);
    check("rst_ptime",   32'(bus8.pulse_time),          32'd0);
    check("rst_valid",   32'(bus8.outgoing_line_valid), 32'd0);
    check("rst_timeout", 32'(bus8.timeout),             32'd0);
    check("rst_busy",    32'(bus8.busy),                32'd0);
    reset = 1'b0;
    step(0, 1'b0, 1'b1);

    // Pulse at offset 3, offset 0, and no pulse at all.
    win(0, 3, 8, 8'h1F, 4'd3, 1'b0, 5);
    win(0, 0, 8, 8'hFF, 4'd0, 1'b0, 2);
    win(0, -1, 8, 8'h00, 4'd8, 1'b1, 9);

    // Line held low from before the window opens.
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0);
    s = cyc;
`ifdef DECODER_PULSE_EDGE_EN
    push(0, 8'h00, 4'd8, 1'b1, s + 9);
`else
    push(0, 8'hFF, 4'd0, 1'b0, s + 2);
`endif
    for (int i = 0; i < 8; i++) step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);

    // Extra window_start during COUNT and a second low pulse after detection.
    step(0, 1'b1, 1'b1);
    s = cyc;
    push(0, 8'h3F, 4'd2, 1'b0, s + 4);
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);

    // Back-to-back: next window_start in the valid cycle of the previous one.
    step(0, 1'b1, 1'b1);
    s = cyc;
    push(0, 8'h7F, 4'd1, 1'b0, s + 3);
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1);
    s = cyc;
    push(0, 8'h0F, 4'd4, 1'b0, s + 6);
    for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);

    // Loopback: encoder fires k = 8 - ones(value) cycles after its load,
    // which coincides with the window opening.
    foreach (vals[j]) begin
      k = 8 - $countones(vals[j]);
      win(0, k, 8, vals[j], 4'(k), 1'b0, k + 2);
    end

    // Reset in window cycle 2: no result, outputs back to reset values.
    step(0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    reset = 1'b1;
    step(0, 1'b0, 1'b0);
    check("midrst_line",  32'(bus8.outgoing_line), 32'h00);
    check("midrst_ptime", 32'(bus8.pulse_time),    32'd0);
    check("midrst_busy",  32'(bus8.busy),          32'd0);
    step(0, 1'b0, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step(0, 1'b0, 1'b1);
    check("postrst_busy", 32'(bus8.busy), 32'd0);

    // Short window instance.
    win(1, -1, 4, 8'h00, 4'd4, 1'b1, 5);
    win(1, 2, 4, 8'h3F, 4'd2, 1'b0, 4);

    for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1);
    check("drain8", 32'(q8.size()), 32'd0);
    check("drain4", 32'(q4.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
